// File: rtl/enigma_step_ctrl_pkg.sv
// Shared types and constants for the Enigma step controller.
// Letters are 5-bit indices 0..25; rotor notches are letter positions.
package enigma_step_ctrl_pkg;

  localparam int         ALPHA       = 26;
  localparam logic [4:0] LAST_LETTER = 5'(ALPHA - 1);

  typedef enum logic [1:0] {
    OP_SET  = 2'd0,
    OP_ENC  = 2'd1,
    OP_ZERO = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SEL_R   = 2'd0,
    SEL_M   = 2'd1,
    SEL_L   = 2'd2,
    SEL_BAD = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Turnover letters of the historical rotors I..V (Q, E, V, J, Z)
  localparam logic [4:0] NOTCH_I   = 5'd16;
  localparam logic [4:0] NOTCH_II  = 5'd4;
  localparam logic [4:0] NOTCH_III = 5'd21;
  localparam logic [4:0] NOTCH_IV  = 5'd9;
  localparam logic [4:0] NOTCH_V   = 5'd25;

  typedef struct packed {
    op_e        op;
    sel_e       sel;
    logic [4:0] data;
  } cmd_t;

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == LAST_LETTER) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic is_letter(input logic [4:0] c);
    return c <= LAST_LETTER;
  endfunction

endpackage

// File: rtl/enigma_step_ctrl_rotor_stepper.sv
// Combinational rotor stepping for one key press.
// Middle rotor also steps on its own notch: the double-step anomaly.
module enigma_rotor_stepper
  import enigma_step_ctrl_pkg::*;
#(
  parameter logic [4:0] NOTCH_R = NOTCH_III,
  parameter logic [4:0] NOTCH_M = NOTCH_II
) (
  input  logic [4:0] i_pos_r,
  input  logic [4:0] i_pos_m,
  input  logic [4:0] i_pos_l,
  output logic [4:0] o_nxt_r,
  output logic [4:0] o_nxt_m,
  output logic [4:0] o_nxt_l
);

  logic w_step_m;
  logic w_step_l;

  assign w_step_l = (i_pos_m == NOTCH_M);
  assign w_step_m = (i_pos_r == NOTCH_R) || w_step_l;

  assign o_nxt_r = inc26(i_pos_r);
  assign o_nxt_m = w_step_m ? inc26(i_pos_m) : i_pos_m;
  assign o_nxt_l = w_step_l ? inc26(i_pos_l) : i_pos_l;

endmodule

// File: rtl/enigma_step_ctrl.sv
// Command sequencer for the Enigma scrambler: owns rotor positions,
// steps them per key press and captures the datapath result.
module enigma_step_ctrl
  import enigma_step_ctrl_pkg::*;
#(
  parameter int NOTCH_R       = 21,
  parameter int NOTCH_M       = 4,
  parameter int NOTCH_L       = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [1:0] i_cmd_sel,
  input  logic [4:0] i_cmd_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [4:0] o_rsp_char,
  output logic       o_rsp_err,
  output logic [4:0] o_pos_r,
  output logic [4:0] o_pos_m,
  output logic [4:0] o_pos_l,
  output logic [4:0] o_dp_char_in,
  input  logic [4:0] i_dp_char_out,
  output logic       o_busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
        NOTCH_R > 25 || NOTCH_M > 25 || NOTCH_L > 25) begin : g_bad_cfg
      $error("enigma_step_ctrl: parameter out of range");
    end
  endgenerate

  state_e     r_state;
  state_e     w_state_nxt;
  cmd_t       r_cmd;
  logic [4:0] r_pos_r;
  logic [4:0] r_pos_m;
  logic [4:0] r_pos_l;
  logic [4:0] r_dp_char;
  logic [4:0] r_rsp_char;
  logic       r_rsp_err;
  logic       r_rsp_valid;
  logic [3:0] r_cnt;

  logic       w_accept;
  logic       w_cmd_err;
  logic [4:0] w_nxt_r;
  logic [4:0] w_nxt_m;
  logic [4:0] w_nxt_l;

  enigma_rotor_stepper #(
    .NOTCH_R (5'(NOTCH_R)),
    .NOTCH_M (5'(NOTCH_M))
  ) u_stepper (
    .i_pos_r (r_pos_r),
    .i_pos_m (r_pos_m),
    .i_pos_l (r_pos_l),
    .o_nxt_r (w_nxt_r),
    .o_nxt_m (w_nxt_m),
    .o_nxt_l (w_nxt_l)
  );

  assign w_accept = i_cmd_valid && o_cmd_ready;

  always_comb begin
    w_cmd_err = 1'b0;
    unique case (r_cmd.op)
      OP_SET:  w_cmd_err = (r_cmd.sel == SEL_BAD) ||
                           !is_letter(r_cmd.data);
      OP_ENC:  w_cmd_err = !is_letter(r_cmd.data);
      OP_ZERO: w_cmd_err = 1'b0;
      default: w_cmd_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (r_cmd.op == OP_ENC && !w_cmd_err)
          w_state_nxt = S_SETTLE;
        else
          w_state_nxt = S_RESP;
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    if (r_state == S_IDLE) begin
      o_cmd_ready = 1'b1;
      o_busy      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd       <= '{op: OP_SET, sel: SEL_R, data: 5'd0};
      r_pos_r     <= 5'd0;
      r_pos_m     <= 5'd0;
      r_pos_l     <= 5'd0;
      r_dp_char   <= 5'd0;
      r_rsp_char  <= 5'd0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cnt       <= 4'd0;
    end else begin
      if (w_accept) begin
        r_cmd <= '{op:   op_e'(i_cmd_op),
                   sel:  sel_e'(i_cmd_sel),
                   data: i_cmd_data};
      end
      unique case (r_state)
        S_EXEC: begin
          if (w_cmd_err) begin
            r_rsp_err   <= 1'b1;
            r_rsp_char  <= 5'd0;
            r_rsp_valid <= 1'b1;
          end else begin
            unique case (r_cmd.op)
              OP_SET: begin
                unique case (r_cmd.sel)
                  SEL_R:   r_pos_r <= r_cmd.data;
                  SEL_M:   r_pos_m <= r_cmd.data;
                  SEL_L:   r_pos_l <= r_cmd.data;
                  default: ;
                endcase
                r_rsp_err   <= 1'b0;
                r_rsp_char  <= 5'd0;
                r_rsp_valid <= 1'b1;
              end
              OP_ZERO: begin
                r_pos_r     <= 5'd0;
                r_pos_m     <= 5'd0;
                r_pos_l     <= 5'd0;
                r_rsp_err   <= 1'b0;
                r_rsp_char  <= 5'd0;
                r_rsp_valid <= 1'b1;
              end
              OP_ENC: begin
                r_pos_r   <= w_nxt_r;
                r_pos_m   <= w_nxt_m;
                r_pos_l   <= w_nxt_l;
                r_dp_char <= r_cmd.data;
                r_cnt     <= SETTLE_LOAD;
              end
              default: ;
            endcase
          end
        end
        S_SETTLE: begin
          // datapath output is only trusted on the final settle edge
          if (r_cnt == 4'd0) begin
            r_rsp_char  <= i_dp_char_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_pos_r      = r_pos_r;
  assign o_pos_m      = r_pos_m;
  assign o_pos_l      = r_pos_l;
  assign o_dp_char_in = r_dp_char;
  assign o_rsp_char   = r_rsp_char;
  assign o_rsp_err    = r_rsp_err;
  assign o_rsp_valid  = r_rsp_valid;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Scoreboard bench for enigma_step_ctrl: driver pushes model results,
// a monitor pops them on each response; stub datapath returns char^1.
module tb_enigma_step_ctrl;

  localparam int SETTLE = 2;
  localparam int NR     = 21;
  localparam int NM     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_op;
  logic [1:0] i_cmd_sel;
  logic [4:0] i_cmd_data;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [4:0] o_rsp_char;
  logic       o_rsp_err;
  logic [4:0] o_pos_r;
  logic [4:0] o_pos_m;
  logic [4:0] o_pos_l;
  logic [4:0] o_dp_char_in;
  logic [4:0] i_dp_char_out;
  logic       o_busy;

  enigma_step_ctrl #(
    .NOTCH_R       (NR),
    .NOTCH_M       (NM),
    .NOTCH_L       (16),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_op      (i_cmd_op),
    .i_cmd_sel     (i_cmd_sel),
    .i_cmd_data    (i_cmd_data),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_char    (o_rsp_char),
    .o_rsp_err     (o_rsp_err),
    .o_pos_r       (o_pos_r),
    .o_pos_m       (o_pos_m),
    .o_pos_l       (o_pos_l),
    .o_dp_char_in  (o_dp_char_in),
    .i_dp_char_out (i_dp_char_out),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int err;
    int r;
    int m;
    int l;
    int acc;
    int lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         stub_acc = -100;
  int         mr = 0;
  int         mm = 0;
  int         ml = 0;
  bit         hold_ready = 1'b0;
  logic [4:0] garbage = 5'd3;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) garbage <= 5'($urandom_range(1, 31));

  // correct value only in the cycle that precedes the capture edge
  assign i_dp_char_out = (cyc == stub_acc + 1 + SETTLE) ?
                         (o_dp_char_in ^ 5'd1) :
                         (o_dp_char_in ^ 5'd1 ^ garbage);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input int op, input int sel, input int data,
                       output exp_t e);
    bit err;
    err = (op == 3) || (op == 0 && (sel == 3 || data > 25)) ||
          (op == 1 && data > 25);
    e.ch  = 0;
    e.err = int'(err);
    e.lat = 1;
    if (!err) begin
      case (op)
        0: begin
          if (sel == 0) mr = data;
          else if (sel == 1) mm = data;
          else ml = data;
        end
        2: begin
          mr = 0;
          mm = 0;
          ml = 0;
        end
        default: begin
          bit sm;
          bit sl;
          sl = (mm == NM);
          sm = (mr == NR) || sl;
          mr = (mr + 1) % 26;
          if (sm) mm = (mm + 1) % 26;
          if (sl) ml = (ml + 1) % 26;
          e.ch  = data ^ 1;
          e.lat = 1 + SETTLE;
        end
      endcase
    end
    e.r   = mr;
    e.m   = mm;
    e.l   = ml;
    e.acc = 0;
  endtask

  task automatic send(input int op, input int sel, input int data);
    exp_t e;
    bit   ok;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'(op);
    i_cmd_sel   = 2'(sel);
    i_cmd_data  = 5'(data);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (o_cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("cmd_accept_timeout", 0, 1);
      i_cmd_valid = 1'b0;
      return;
    end
    model(op, sel, data, e);
    e.acc    = cyc;
    stub_acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !o_busy && !o_rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_pos(input string nm, input int l, input int m, input int r);
    chk({nm, "_l"}, int'(o_pos_l), l);
    chk({nm, "_m"}, int'(o_pos_m), m);
    chk({nm, "_r"}, int'(o_pos_r), r);
  endtask

  // monitor: pops one expectation per response, checks hold while stalled
  initial begin
    bit         seen;
    bit         prev_hs;
    exp_t       cur;
    logic [4:0] hc;
    logic       he;
    seen        = 1'b0;
    prev_hs     = 1'b0;
    hc          = 5'd0;
    he          = 1'b0;
    i_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen        = 1'b0;
        prev_hs     = 1'b0;
        i_rsp_ready = 1'b0;
        continue;
      end
      if (prev_hs) begin
        chk("rsp_valid_drop", int'(o_rsp_valid), 0);
        seen = 1'b0;
      end
      prev_hs = 1'b0;
      if (o_rsp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            cur = sb.pop_front();
            chk("latency", cyc - cur.acc, cur.lat + 1);
            chk("rsp_char", int'(o_rsp_char), cur.ch);
            chk("rsp_err", int'(o_rsp_err), cur.err);
            chk("pos_r", int'(o_pos_r), cur.r);
            chk("pos_m", int'(o_pos_m), cur.m);
            chk("pos_l", int'(o_pos_l), cur.l);
          end
          hc = o_rsp_char;
          he = o_rsp_err;
        end else begin
          chk("rsp_char_stable", int'(o_rsp_char), int'(hc));
          chk("rsp_err_stable", int'(o_rsp_err), int'(he));
          chk("cmd_ready_in_resp", int'(o_cmd_ready), 0);
        end
        i_rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
        prev_hs     = i_rsp_ready;
      end else begin
        i_rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    bit ok;
    int op;
    int sel;
    int data;
    int pick;
    int set_vals[6];
    set_vals    = '{20, 21, 3, 4, 25, 0};
    i_cmd_valid = 1'b0;
    i_cmd_op    = 2'd0;
    i_cmd_sel   = 2'd0;
    i_cmd_data  = 5'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_pos("reset_pos", 0, 0, 0);
    chk("reset_rsp_valid", int'(o_rsp_valid), 0);
    chk("reset_cmd_ready", int'(o_cmd_ready), 1);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_dp_char", int'(o_dp_char_in), 0);
    rst = 1'b0;

    // double step: ADU -> ADV -> AEW -> BFX
    send(0, 2, 0);
    send(0, 1, 3);
    send(0, 0, 20);
    wait_idle();
    chk_pos("adu", 0, 3, 20);
    send(1, 0, 7);
    wait_idle();
    chk_pos("adv", 0, 3, 21);
    send(1, 0, 8);
    wait_idle();
    chk_pos("aew", 0, 4, 22);
    send(1, 0, 9);
    wait_idle();
    chk_pos("bfx", 1, 5, 23);

    // wrap: R=25 goes to 0 without turning M
    send(0, 0, 25);
    send(0, 1, 0);
    send(1, 0, 3);
    wait_idle();
    chk_pos("wrap", 1, 0, 0);

    // 'A' through the stub gives 1, latency checked by the monitor
    send(1, 0, 0);
    wait_idle();
    chk("enc_a_char", int'(o_rsp_char), 1);
    chk_pos("enc_a", 1, 0, 1);

    // rejected commands leave positions alone
    send(1, 0, 26);
    send(0, 3, 5);
    send(3, 0, 0);
    send(0, 1, 30);
    wait_idle();
    chk_pos("errs", 1, 0, 1);

    // backpressure with an ignored command pulse
    hold_ready = 1'b1;
    send(1, 0, 12);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bp_rsp_timeout", 0, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_cmd_ready", int'(o_cmd_ready), 0);
      chk("bp_rsp_valid", int'(o_rsp_valid), 1);
      chk("bp_pos_r", int'(o_pos_r), 2);
      i_cmd_valid = (k == 4);
      i_cmd_op    = 2'd2;
    end
    i_cmd_valid = 1'b0;
    hold_ready  = 1'b0;
    wait_idle();
    chk("bp_cmd_ready_after", int'(o_cmd_ready), 1);
    chk_pos("bp_after", 1, 0, 2);

    // reset during SETTLE drops the command
    send(0, 0, 5);
    wait_idle();
    send(1, 0, 4);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_pos("rst_mid", 0, 0, 0);
    chk("rst_mid_rsp_valid", int'(o_rsp_valid), 0);
    chk("rst_mid_busy", int'(o_busy), 0);
    chk("rst_mid_cmd_ready", int'(o_cmd_ready), 1);
    sb.delete();
    mr       = 0;
    mm       = 0;
    ml       = 0;
    stub_acc = -100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_rsp_busy", int'(o_busy), 0);
    chk("rst_no_rsp_valid", int'(o_rsp_valid), 0);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      pick = int'($urandom_range(0, 9));
      sel  = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 90) data = int'($urandom_range(0, 25));
      else data = int'($urandom_range(26, 31));
      if (pick < 6) begin
        op = 1;
      end else if (pick < 8) begin
        op = 0;
        if ($urandom_range(0, 1) == 1) data = set_vals[$urandom_range(0, 5)];
      end else if (pick == 8) begin
        op = 2;
      end else begin
        op = 3;
      end
      send(op, sel, data);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    chk_pos("rand_final", ml, mm, mr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
